hgc_vram_isa_port: RTL and testbench

//  ISA memory-side writer/reader for Hercules video RAM: the CPU-facing end of the VRAM that the

---
 rtl/hgc_vram_isa_port.sv | 242 ++++++++++++++++++++++++
 tb/tb_hgc_vram_isa_port.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hgc_vram_isa_port.sv
// hgc_vram_isa_port
// CPU-facing port of the Hercules video RAM. Decodes ISA memory cycles in
// B0000-B7FFF (and B8000-BFFFF when page 1 is enabled), holds the ISA bus in
// wait states until the sequencer grants a free RAM slot, then performs one
// RAM access. Outside that access the display fetch address passes straight
// through to the RAM.
//
// Build option: define HGC_VRAM_READ_EN to include the CPU read path (read
// strobe synchroniser, read-latency counter, bus_out/bus_dir drivers). Without
// it only writes are decoded and the read-side outputs are held inactive.

module hgc_vram_isa_port #(
    parameter logic [7:0] WAIT_MAX = 8'd31,
    parameter logic [1:0] RD_LAT   = 2'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    input  logic [1:0]  config_sw,
    input  logic        isa_op_enable,
    input  logic [18:0] pixel_addr,
    input  logic        pixel_read,
    output logic [18:0] ram_a,
    input  logic [7:0]  ram_d,
    output logic [7:0]  ram_dout,
    output logic        ram_we_l
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        ACCESS    = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    // [0],[1] form the synchroniser; [2] is the previous synced value for edge detect
    logic [2:0]  memw_sync_q, memw_sync_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        bus_rdy_q, bus_rdy_d;
    logic        ram_we_l_q, ram_we_l_d;
    logic [7:0]  ram_dout_q, ram_dout_d;

    logic        page_hit;
    logic        wr_fall;
    logic        wr_low;
    logic        slot_free;
    logic        wait_expired;
    logic        strobe_high;
    logic [7:0]  wait_cnt_inc;
    logic        unused_ok;

`ifdef HGC_VRAM_READ_EN
    logic [2:0]  memr_sync_q, memr_sync_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  rd_cnt_q, rd_cnt_d;
    logic        bus_dir_q, bus_dir_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        rd_fall;
    logic        rd_done;
`endif

    // Page 0 is always mapped; page 1 only when the 3BF switch enables it.
    assign page_hit = !bus_aen &&
                      ((bus_a[19:15] == 5'b10110) ||
                       ((bus_a[19:15] == 5'b10111) && config_sw[1]));

    assign wr_fall      = memw_sync_q[2] && !memw_sync_q[1];
    assign wr_low       = !memw_sync_q[1];
    assign slot_free    = isa_op_enable && !pixel_read;
    assign wait_cnt_inc = wait_cnt_q + 8'd1;
    assign wait_expired = (wait_cnt_inc == WAIT_MAX);

`ifdef HGC_VRAM_READ_EN
    assign rd_fall     = memr_sync_q[2] && !memr_sync_q[1];
    assign rd_done     = (rd_cnt_q == (RD_LAT - 2'd1));
    // The cycle ends when the strobe that started it is released.
    assign strobe_high = is_wr_q ? memw_sync_q[1] : memr_sync_q[1];
    assign unused_ok   = config_sw[0];
`else
    assign strobe_high = memw_sync_q[1];
    assign unused_ok   = ^{config_sw[0], bus_memr_l, ram_d, RD_LAT};
`endif

    // Next-state logic for the access FSM, synchronisers and registered bus/RAM outputs.
    always_comb begin
        memw_sync_d = {memw_sync_q[1:0], bus_memw_l};
        state_d     = state_q;
        addr_d      = addr_q;
        wait_cnt_d  = wait_cnt_q;
        bus_rdy_d   = bus_rdy_q;
        ram_we_l_d  = 1'b1;
        ram_dout_d  = ram_dout_q;
`ifdef HGC_VRAM_READ_EN
        memr_sync_d = {memr_sync_q[1:0], bus_memr_l};
        is_wr_d     = is_wr_q;
        rd_cnt_d    = rd_cnt_q;
        bus_dir_d   = bus_dir_q;
        bus_out_d   = bus_out_q;
`endif
        case (state_q)
            IDLE: begin
                // A write edge wins over a read; a read edge seen while the
                // write strobe is also low is ignored.
                if (page_hit && wr_fall) begin
                    state_d    = WAIT_SLOT;
                    addr_d     = bus_a[15:0];
                    ram_dout_d = bus_d;
                    bus_rdy_d  = 1'b0;
                    wait_cnt_d = 8'd0;
`ifdef HGC_VRAM_READ_EN
                    is_wr_d    = 1'b1;
`endif
                end
`ifdef HGC_VRAM_READ_EN
                else if (page_hit && rd_fall && !wr_low) begin
                    state_d    = WAIT_SLOT;
                    addr_d     = bus_a[15:0];
                    bus_rdy_d  = 1'b0;
                    bus_dir_d  = 1'b1;
                    wait_cnt_d = 8'd0;
                    is_wr_d    = 1'b0;
                end
`endif
            end
            WAIT_SLOT: begin
                if (strobe_high) begin
                    // CPU gave up before the RAM was touched: drop the cycle.
                    state_d    = IDLE;
                    bus_rdy_d  = 1'b1;
                    wait_cnt_d = 8'd0;
`ifdef HGC_VRAM_READ_EN
                    bus_dir_d  = 1'b0;
`endif
                end else if (slot_free || wait_expired) begin
                    // Either a free slot or the wait budget ran out (snow is
                    // accepted rather than stalling the ISA bus further).
                    state_d    = ACCESS;
                    wait_cnt_d = 8'd0;
`ifdef HGC_VRAM_READ_EN
                    ram_we_l_d = !is_wr_q;
                    rd_cnt_d   = 2'd0;
`else
                    ram_we_l_d = 1'b0;
`endif
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            ACCESS: begin
`ifdef HGC_VRAM_READ_EN
                if (is_wr_q) begin
                    state_d   = HOLD;
                    bus_rdy_d = 1'b1;
                end else if (rd_done) begin
                    state_d   = HOLD;
                    bus_rdy_d = 1'b1;
                    bus_out_d = ram_d;
                    rd_cnt_d  = 2'd0;
                end else begin
                    rd_cnt_d  = rd_cnt_q + 2'd1;
                end
`else
                state_d   = HOLD;
                bus_rdy_d = 1'b1;
`endif
            end
            HOLD: begin
                if (strobe_high) begin
                    state_d   = IDLE;
`ifdef HGC_VRAM_READ_EN
                    bus_dir_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, synchronisers and registered outputs; reset idles the bus and kills any RAM write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            memw_sync_q <= 3'b111;
            wait_cnt_q  <= 8'd0;
            bus_rdy_q   <= 1'b1;
            ram_we_l_q  <= 1'b1;
            ram_dout_q  <= 8'h00;
`ifdef HGC_VRAM_READ_EN
            memr_sync_q <= 3'b111;
            is_wr_q     <= 1'b1;
            rd_cnt_q    <= 2'd0;
            bus_dir_q   <= 1'b0;
            bus_out_q   <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            memw_sync_q <= memw_sync_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_rdy_q   <= bus_rdy_d;
            ram_we_l_q  <= ram_we_l_d;
            ram_dout_q  <= ram_dout_d;
`ifdef HGC_VRAM_READ_EN
            memr_sync_q <= memr_sync_d;
            is_wr_q     <= is_wr_d;
            rd_cnt_q    <= rd_cnt_d;
            bus_dir_q   <= bus_dir_d;
            bus_out_q   <= bus_out_d;
`endif
        end
    end

    // Latched CPU address; only meaningful while a cycle is in flight, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    // The CPU address owns the RAM only during ACCESS; otherwise display fetch passes through.
    assign ram_a    = (state_q == ACCESS) ? {3'b000, addr_q} : pixel_addr;
    assign ram_we_l = ram_we_l_q;
    assign ram_dout = ram_dout_q;
    assign bus_rdy  = bus_rdy_q;

`ifdef HGC_VRAM_READ_EN
    assign bus_dir  = bus_dir_q;
    assign bus_out  = bus_out_q;
`else
    assign bus_dir  = 1'b0;
    assign bus_out  = 8'h00;
`endif

endmodule

// File: tb/tb_hgc_vram_isa_port.sv
// Testbench for hgc_vram_isa_port: random and directed ISA cycles, a memory
// reference model for expected read/write results, and a scoreboard monitor.
`timescale 1ns/1ps

module tb_hgc_vram_isa_port;

    localparam logic [7:0] WAIT_MAX = 8'd31;
    localparam logic [1:0] RD_LAT   = 2'd1;
`ifdef HGC_VRAM_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic        bus_aen;
    logic [7:0]  bus_out;
    logic        bus_dir;
    logic        bus_rdy;
    logic [1:0]  config_sw;
    logic        isa_op_enable;
    logic [18:0] pixel_addr;
    logic        pixel_read;
    logic [18:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_dout;
    logic        ram_we_l;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  vram    [0:524287];
    logic [7:0]  ref_mem [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;
    int          bg_mode  = 1;

    hgc_vram_isa_port #(.WAIT_MAX(WAIT_MAX), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
        .config_sw(config_sw), .isa_op_enable(isa_op_enable),
        .pixel_addr(pixel_addr), .pixel_read(pixel_read),
        .ram_a(ram_a), .ram_d(ram_d), .ram_dout(ram_dout), .ram_we_l(ram_we_l)
    );

    // Asynchronous RAM: data for the current address is available in the same cycle.
    assign ram_d = vram[ram_a];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Address map the CPU sees.
    function automatic bit decodes(input logic [19:0] a, input logic [1:0] cfg, input bit aen);
        if (aen) return 1'b0;
        if (a >= 20'hB0000 && a <= 20'hB7FFF) return 1'b1;
        if (a >= 20'hB8000 && a <= 20'hBFFFF && cfg[1]) return 1'b1;
        return 1'b0;
    endfunction

    // Sequencer / display traffic.
    initial begin
        isa_op_enable = 1'b0;
        pixel_read    = 1'b0;
        pixel_addr    = '0;
        forever begin
            @(posedge clk);
            #1;
            pixel_addr = 19'($urandom);
            case (bg_mode)
                0: begin
                    isa_op_enable = ($urandom_range(0, 3) == 0);
                    pixel_read    = ($urandom_range(0, 1) == 1);
                end
                1: begin isa_op_enable = 1'b0; pixel_read = 1'b0; end
                2: begin isa_op_enable = 1'b1; pixel_read = 1'b0; end
                default: begin isa_op_enable = 1'b1; pixel_read = 1'b1; end
            endcase
        end
    end

    // Scoreboard monitor: RAM writes and read completions are popped against expectations.
    initial begin
        bit         we_prev_low;
        bit         rdy_prev;
        wr_t        e;
        logic [7:0] er;
        we_prev_low = 1'b0;
        rdy_prev    = 1'b1;
        forever begin
            @(negedge clk);
            if (we_prev_low)
                chk(ram_we_l && bus_rdy, "we_pulse_end", 32'({ram_we_l, bus_rdy}), 32'h3);
            if (!ram_we_l) begin
                vram[ram_a] = ram_dout;
                if (exp_wr_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", 32'({ram_a, ram_dout}), 32'h0);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk(ram_a == e.a && ram_dout == e.d, "write_addr_data",
                        32'({ram_a, ram_dout}), 32'({e.a, e.d}));
                end
                chk(!bus_rdy, "rdy_low_at_write", 32'(bus_rdy), 32'h0);
            end
            if (bus_rdy && !rdy_prev && bus_dir) begin
                if (exp_rd_q.size() == 0) begin
                    chk(1'b0, "unexpected_read", 32'(bus_out), 32'h0);
                end else begin
                    er = exp_rd_q.pop_front();
                    chk(bus_out == er, "read_data", 32'(bus_out), 32'(er));
                end
            end
            we_prev_low = !ram_we_l;
            rdy_prev    = bus_rdy;
        end
    end

    // One ISA memory cycle; low returns how many samples bus_rdy was held low.
    task automatic isa_cycle(input bit do_wr, input bit do_rd, input logic [19:0] a,
                             input logic [7:0] d, input logic [1:0] cfg, input bit aen,
                             output int low);
        bit          hit;
        bit          seen;
        int          n;
        logic [15:0] off;
        bus_a     = a;
        bus_d     = d;
        config_sw = cfg;
        bus_aen   = aen;
        low       = 0;
        tick();
        off = a[15:0];
        hit = decodes(a, cfg, aen) && (do_wr || READ_EN);
        if (hit && do_wr) begin
            exp_wr_q.push_back('{{3'b000, off}, d});
            ref_mem[off] = d;
        end else if (hit) begin
            exp_rd_q.push_back(ref_mem[off]);
        end
        bus_memw_l = !do_wr;
        bus_memr_l = !do_rd;
        if (hit) begin
            n = 0;
            while (bus_rdy && n < 8) begin tick(); n++; end
            chk(!bus_rdy, "rdy_drop", 32'(bus_rdy), 32'h0);
            while (!bus_rdy && low < int'(WAIT_MAX) + 12) begin low++; tick(); end
            chk(bus_rdy, "rdy_return", 32'(bus_rdy), 32'h1);
            if (!do_wr) chk(bus_dir, "dir_held", 32'(bus_dir), 32'h1);
        end else begin
            seen = 1'b0;
            repeat (8) begin
                tick();
                if (!bus_rdy || bus_dir) seen = 1'b1;
`ifndef HGC_VRAM_READ_EN
                if (bus_out != 8'h00) seen = 1'b1;
`endif
            end
            chk(!seen, "undecoded_idle", 32'({bus_rdy, bus_dir}), 32'h2);
        end
        bus_memw_l = 1'b1;
        bus_memr_l = 1'b1;
        repeat (4) tick();
        chk(bus_rdy && !bus_dir && ram_a == pixel_addr, "idle_after_release",
            32'({bus_rdy, bus_dir, ram_a}), 32'({2'b10, pixel_addr}));
    endtask

    initial begin #500_000; $display("FAIL watchdog checks=%0d", n_checks); $fatal(1, "timeout"); end

    initial begin
        int          low;
        int          r;
        logic [19:0] a;
        for (int i = 0; i < 524288; i++) begin
            vram[i] = (i < 65536) ? 8'($urandom) : i[7:0];
            if (i < 65536) ref_mem[i] = vram[i];
        end
        vram[19'h00123]  = 8'h5A;
        ref_mem[16'h0123] = 8'h5A;
        reset = 1'b1; bus_a = '0; bus_d = '0; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        bus_aen = 1'b0; config_sw = 2'b00;
        repeat (3) tick();
        chk(bus_rdy == 1'b1, "rst_rdy", 32'(bus_rdy), 32'h1);
        chk(bus_dir == 1'b0, "rst_dir", 32'(bus_dir), 32'h0);
        chk(bus_out == 8'h00, "rst_out", 32'(bus_out), 32'h0);
        chk(ram_we_l == 1'b1, "rst_we", 32'(ram_we_l), 32'h1);
        chk(ram_dout == 8'h00, "rst_dout", 32'(ram_dout), 32'h0);
        reset = 1'b0;
        repeat (2) tick();
        chk(ram_a == pixel_addr, "rst_passthru", 32'(ram_a), 32'(pixel_addr));

        // Read B0123 holding 5A, then write A5 with a slot four clocks later.
        bg_mode = 2;
        isa_cycle(1'b0, 1'b1, 20'hB0123, 8'h00, 2'b00, 1'b0, low);
        bg_mode = 1;
        fork
            isa_cycle(1'b1, 1'b0, 20'hB0123, 8'hA5, 2'b00, 1'b0, low);
            begin repeat (4) tick(); bg_mode = 2; end
        join
        chk(low >= 1 && low <= 8, "slot_write_wait", 32'(low), 32'h8);
        isa_cycle(1'b0, 1'b1, 20'hB0123, 8'h00, 2'b00, 1'b0, low);

        // Page 1 gating.
        isa_cycle(1'b1, 1'b0, 20'hB8000, 8'h3C, 2'b00, 1'b0, low);
        isa_cycle(1'b1, 1'b0, 20'hB8000, 8'h3C, 2'b10, 1'b0, low);

        // No slot at all, then slots always stolen by the display: forced access.
        bg_mode = 1;
        isa_cycle(1'b1, 1'b0, 20'hB0456, 8'h81, 2'b00, 1'b0, low);
        chk(low >= int'(WAIT_MAX) && low <= int'(WAIT_MAX) + int'(RD_LAT) + 3,
            "forced_wait", 32'(low), 32'(WAIT_MAX));
        bg_mode = 3;
        isa_cycle(1'b1, 1'b0, 20'hB0457, 8'h18, 2'b00, 1'b0, low);
        chk(low >= int'(WAIT_MAX), "pixel_wins", 32'(low), 32'(WAIT_MAX));
        bg_mode = 1;
        isa_cycle(1'b0, 1'b1, 20'hB0456, 8'h00, 2'b00, 1'b0, low);

        // DMA cycle, and both strobes low together.
        bg_mode = 2;
        isa_cycle(1'b1, 1'b0, 20'hB0000, 8'hEE, 2'b00, 1'b1, low);
        isa_cycle(1'b1, 1'b1, 20'hB0789, 8'h99, 2'b00, 1'b0, low);
        isa_cycle(1'b0, 1'b1, 20'hB0789, 8'h00, 2'b00, 1'b0, low);

        // Aborted write: strobe released while still waiting for a slot.
        bg_mode = 1;
        bus_a = 20'hB0999; bus_d = 8'h42; config_sw = 2'b00; bus_aen = 1'b0;
        tick();
        bus_memw_l = 1'b0;
        repeat (6) tick();
        chk(!bus_rdy, "abort_wait", 32'(bus_rdy), 32'h0);
        bus_memw_l = 1'b1;
        repeat (5) tick();
        chk(bus_rdy && !bus_dir, "abort_idle", 32'({bus_rdy, bus_dir}), 32'h2);
        bg_mode = 2;
        repeat (10) tick();

        // Reset while waiting for a slot.
        bg_mode = 1;
        bus_a = 20'hB0200; bus_d = 8'h77;
        tick();
        bus_memw_l = 1'b0;
        repeat (6) tick();
        chk(!bus_rdy, "wait_before_reset", 32'(bus_rdy), 32'h0);
        reset = 1'b1;
        #1;
        chk(bus_rdy && ram_we_l, "async_reset", 32'({bus_rdy, ram_we_l}), 32'h3);
        bus_memw_l = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bg_mode = 2;
        repeat (10) tick();
        chk(bus_rdy && !bus_dir, "after_reset_idle", 32'({bus_rdy, bus_dir}), 32'h2);

        // Random traffic.
        bg_mode = 0;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 3);
            if (r == 3) a = 20'($urandom);
            else a = ((r == 2) ? 20'hB8000 : 20'hB0000) +
                     (($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 15)) : 20'($urandom_range(0, 32767)));
            r = $urandom_range(0, 4);
            isa_cycle(r != 1, r <= 1, a, 8'($urandom), 2'($urandom), $urandom_range(0, 9) == 0, low);
        end

        repeat (10) tick();
        chk(exp_wr_q.size() == 0, "wr_queue_empty", 32'(exp_wr_q.size()), 32'h0);
        chk(exp_rd_q.size() == 0, "rd_queue_empty", 32'(exp_rd_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
